// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator program sequencer:
// FSM state encoding, opcode values and instruction field positions.
package acc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_JMP  = 4'd3;
    localparam logic [3:0] OP_JZ   = 4'd4;
    localparam logic [3:0] OP_HALT = 4'd5;

    // Instruction word layout: operand [8:5], opcode [4:1], bit 0 passed through
    localparam int OPC_HI = 4;
    localparam int OPC_LO = 1;
    localparam int OPR_HI = 8;
    localparam int OPR_LO = 5;

    // True for opcodes that the datapath executes (and so need a write strobe)
    function automatic logic is_dp_op(input logic [3:0] opc);
        return (opc == OP_ADDI) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/acc_seq_imem.sv
// Instruction memory: DEPTH x 9 bits, one write port, one registered read
// port. No reset; contents are don't-care until a program is loaded.
module acc_seq_imem #(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic [8:0]    wr_data,
    input  logic          rd_en,
    input  logic [PW-1:0] rd_addr,
    output logic [8:0]    rd_data
);

    logic [8:0] mem_r [DEPTH];

    // Program write and synchronous read of the word at the fetch address
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/acc_sequencer.sv
// Program sequencer for the 9-bit accumulator datapath. Loads a program over
// a valid/ready stream, then fetches and issues it, resolving JMP/JZ/HALT
// locally and strobing WRITE_EN only for datapath ops.
// Optional feature macro: ACC_SEQ_STEP_EN (single-step on STEP rising edges).
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          LOAD_VALID,
    input  logic [8:0]    LOAD_DATA,
    input  logic          LOAD_LAST,
    output logic          LOAD_READY,
    input  logic          START,
    input  logic          STEP,
    input  logic          ACC_ZERO,
    output logic [8:0]    INSTR_OUT,
    output logic          WRITE_EN,
    output logic [PW-1:0] PC,
    output logic          BUSY,
    output logic          HALTED,
    output logic          ERR
);

    localparam int LW = PW + 1;  // holds 0..DEPTH
    localparam int CW = 9;       // common compare width for operand, PC and length

    state_t          state_r;
    logic [PW-1:0]   pc_r;
    logic [LW-1:0]   count_r;
    logic [LW-1:0]   len_r;
    logic [8:0]      instr_r;
    logic            wen_r;
    logic            busy_r;
    logic            halted_r;
    logic            err_r;
    logic            step_q_r;
    logic            step_wait_r;

    logic            ready_s;
    logic            hs_s;
    logic [PW-1:0]   wr_addr_s;
    logic            rd_en_s;
    logic [8:0]      rd_data_s;
    logic [3:0]      opc_s;
    logic [3:0]      opr_s;
    logic            jump_s;
    logic            halt_s;
    logic            tgt_bad_s;
    logic            last_s;
    logic [CW-1:0]   pc_inc_s;
    logic            step_rise_s;

    acc_seq_imem #(.DEPTH(DEPTH), .PW(PW)) u_imem (
        .CLK     (CLK),
        .wr_en   (hs_s),
        .wr_addr (wr_addr_s),
        .wr_data (LOAD_DATA),
        .rd_en   (rd_en_s),
        .rd_addr (pc_r),
        .rd_data (rd_data_s)
    );

    // Load acceptance depends only on state and fill level, never on LOAD_VALID
    always_comb begin
        case (state_r)
            S_IDLE, S_DONE: ready_s = 1'b1;
            S_LOAD:         ready_s = (count_r != LW'(DEPTH));
            default:        ready_s = 1'b0;
        endcase
    end

    // Handshake, write addressing and decode of the fetched word
    always_comb begin
        hs_s        = LOAD_VALID & ready_s;
        rd_en_s     = (state_r == S_FETCH);
        step_rise_s = STEP & ~step_q_r;
        if (state_r == S_LOAD) begin
            wr_addr_s = count_r[PW-1:0];
        end else begin
            wr_addr_s = {PW{1'b0}};
        end
        opc_s     = rd_data_s[OPC_HI:OPC_LO];
        opr_s     = rd_data_s[OPR_HI:OPR_LO];
        halt_s    = (opc_s == OP_HALT);
        jump_s    = (opc_s == OP_JMP) || ((opc_s == OP_JZ) && ACC_ZERO);
        tgt_bad_s = (CW'(opr_s) >= CW'(len_r));
        pc_inc_s  = CW'(pc_r) + CW'(1);
        last_s    = (pc_inc_s == CW'(len_r));
    end

    // Registered edge detector for single-step requests
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step_q_r <= 1'b0;
        end else begin
            step_q_r <= STEP;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r     <= S_IDLE;
            pc_r        <= {PW{1'b0}};
            count_r     <= {LW{1'b0}};
            len_r       <= {LW{1'b0}};
            instr_r     <= 9'h000;
            wen_r       <= 1'b0;
            busy_r      <= 1'b0;
            halted_r    <= 1'b0;
            err_r       <= 1'b0;
            step_wait_r <= 1'b0;
        end else begin
            wen_r <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (hs_s) begin
                        count_r  <= LW'(1);
                        err_r    <= 1'b0;
                        halted_r <= 1'b0;
                        if (LOAD_LAST) begin
                            len_r   <= LW'(1);
                            state_r <= S_IDLE;
                        end else begin
                            state_r <= S_LOAD;
                        end
                    end else if (START && (len_r != {LW{1'b0}})) begin
                        pc_r     <= {PW{1'b0}};
                        err_r    <= 1'b0;
                        halted_r <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= S_FETCH;
                    end
                end
                S_LOAD: begin
                    if (LOAD_VALID) begin
                        if (count_r == LW'(DEPTH)) begin
                            // word beyond capacity: keep the full image, flag it
                            err_r   <= 1'b1;
                            len_r   <= LW'(DEPTH);
                            state_r <= S_IDLE;
                        end else begin
                            count_r <= count_r + LW'(1);
                            if (LOAD_LAST) begin
                                len_r   <= count_r + LW'(1);
                                state_r <= S_IDLE;
                            end
                        end
                    end
                end
                S_FETCH: begin
                    state_r <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (step_wait_r) begin
                        // word already issued; only a fresh STEP edge moves on
                        if (step_rise_s) begin
                            step_wait_r <= 1'b0;
                            state_r     <= S_FETCH;
                        end
                    end else begin
                        instr_r <= rd_data_s;
                        wen_r   <= is_dp_op(opc_s);
                        if (halt_s || (jump_s && tgt_bad_s) || (!jump_s && last_s)) begin
                            err_r    <= jump_s & tgt_bad_s & ~halt_s;
                            busy_r   <= 1'b0;
                            halted_r <= 1'b1;
                            state_r  <= S_DONE;
                        end else begin
                            if (jump_s) begin
                                pc_r <= PW'(opr_s);
                            end else begin
                                pc_r <= pc_r + PW'(1);
                            end
`ifdef ACC_SEQ_STEP_EN
                            step_wait_r <= 1'b1;
`else
                            state_r <= S_FETCH;
`endif
                        end
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign LOAD_READY = ready_s;
    assign INSTR_OUT  = instr_r;
    assign WRITE_EN   = wen_r;
    assign PC         = pc_r;
    assign BUSY       = busy_r;
    assign HALTED     = halted_r;
    assign ERR        = err_r;

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Program sequencer for the 9-bit accumulator datapath. It loads a short program over a valid/ready stream into a local instruction memory. On START it fetches and issues each word to the datapath's INSTRUCTION/write_en inputs, and it resolves jumps, conditional jumps and halt itself. It sits between the chip I/O shim and the accumulator core, and is the only driver of the core's write_en.

## Interface
Parameters:
- DEPTH, 16, instruction memory words; power of two, 2..256
- PW, $clog2(DEPTH), PC width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- LOAD_VALID  in  1  program word present
- LOAD_DATA  in  9  program word
- LOAD_LAST  in  1  qualifies final word of program
- LOAD_READY  out  1  sequencer accepts a word this cycle
- START  in  1  begin execution from address 0 (level, sampled)
- STEP  in  1  single-step advance; used only when ACC_SEQ_STEP_EN is defined
- ACC_ZERO  in  1  datapath accumulator == 0
- INSTR_OUT  out  9  word to datapath INSTRUCTION
- WRITE_EN  out  1  datapath write_en strobe
- PC  out  PW  address of the word being fetched or issued
- BUSY  out  1  state is FETCH or ISSUE
- HALTED  out  1  program ended
- ERR  out  1  sticky fault, cleared by START or a new load

## Operation
- Word format: opcode = [4:1], operand = [8:5], bit 0 is passed through.
- Opcodes 0 ADDI, 1 ADD and 2 SUB are datapath ops. These are issued with WRITE_EN=1.
- Opcode 3 is JMP. Opcode 4 is JZ (taken when ACC_ZERO=1). Opcode 5 is HALT. Opcodes 6..15 are NOP. None of these assert WRITE_EN.
- States are IDLE, LOAD, FETCH, ISSUE and DONE.
- IDLE:
  - A handshake (LOAD_VALID & LOAD_READY) writes the word to mem[0], sets count=1 and clears ERR.
  - Next state is LOAD, or stays IDLE with len=1 if LOAD_LAST.
  - START with len>0 sets PC=0 and goes to FETCH. START with len=0 is ignored.
  - LOAD_VALID has priority over START in the same cycle.
- LOAD:
  - Each handshake writes mem[count] and increments count.
  - LOAD_LAST stores len=count+1 and returns to IDLE.
  - LOAD_READY=0 once count==DEPTH. From then on the next LOAD_VALID sets ERR, len=DEPTH, and returns to IDLE.
- FETCH: synchronous memory read of mem[PC], then go to ISSUE.
- ISSUE: INSTR_OUT is registered from the fetched word.
  - Datapath op or NOP: PC+1. If PC+1==len, go to DONE; otherwise go to FETCH.
  - JMP: PC=operand. JZ taken: PC=operand. JZ not taken: PC+1.
  - Jump target >= len: set ERR and go to DONE.
  - HALT: go to DONE.
- DONE: HALTED=1. START restarts at PC=0. LOAD_VALID begins a new load (ERR cleared, go to LOAD).
- START while BUSY is ignored. The sequencer never modifies the accumulator directly.
- Any RESET assertion, including mid-run or mid-load, drops to IDLE with len=0. Memory contents become don't-care.

## Timing
- Reset values:
  - LOAD_READY=1
  - INSTR_OUT=9'h000
  - WRITE_EN=0
  - PC=0
  - BUSY=0
  - HALTED=0
  - ERR=0
- Throughput is 2 cycles per instruction (FETCH and ISSUE).
- WRITE_EN is high for exactly one cycle, coincident with INSTR_OUT valid in ISSUE. The datapath captures on the following edge.
- INSTR_OUT holds its last value outside ISSUE.
- JZ samples ACC_ZERO in the ISSUE cycle. The update from the previous op is already visible, because issues are at least 2 cycles apart.
- LOAD_READY is combinational from state/count only, never from LOAD_VALID.
- START to first WRITE_EN takes 2 cycles.

## Configuration
- ACC_SEQ_STEP_EN defined:
  - After each ISSUE the FSM waits in ISSUE-exit until a rising edge of STEP, detected by a registered edge detector, before entering FETCH.
  - BUSY stays 1 while waiting.
  - A STEP edge in any other state is ignored.
- ACC_SEQ_STEP_EN undefined: STEP is ignored and the sequencer runs freely. The port remains present.

## Structure
- Shared package acc_seq_pkg holds:
  - opcode localparams (OP_ADDI, OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_HALT)
  - state encodings (S_IDLE, S_LOAD, S_FETCH, S_ISSUE, S_DONE)
  - field slice constants for opcode [4:1] and operand [8:5]
- Sub-module acc_seq_imem: DEPTH×9 memory, one write port, one registered read port, no reset.

## Test plan
- Load program with LOAD_LAST on the 3rd word:
  - Program: ADDI 3 (9'h060), ADD (9'h002), HALT (9'h00A).
  - Pulse START.
  - Required: WRITE_EN at cycles +2 and +4 with INSTR_OUT 9'h060 then 9'h002; HALTED at +6; PC=2.
- Program [ADDI 0, JZ 3, ADDI 1, HALT] with ACC_ZERO=1 held:
  - JZ is taken and ADDI 1 is never issued.
  - Repeat with ACC_ZERO=0: ADDI 1 is issued.
- JMP 9 in a 4-word program: ERR=1 and HALTED=1. No WRITE_EN after the jump.
- Stream 17 words into DEPTH=16 with no LOAD_LAST:
  - LOAD_READY drops after the 16th word.
  - The 17th LOAD_VALID sets ERR. len=16.
- RESET asserted during ISSUE of the 2nd instruction:
  - All outputs return to reset values immediately.
  - START is then ignored until a new load.
- With ACC_SEQ_STEP_EN defined, a 3-op program:
  - One WRITE_EN per STEP rising edge.
  - Holding STEP high yields no further issues.
